// File: rtl/coord_scan_gen_if.sv
// Point stream from coord_scan_gen to the block-matching stage.
interface coord_scan_gen_if #(
  parameter int WIDTH = 8
);
  logic                    out_valid;
  logic                    out_ready;
  logic signed [WIDTH-1:0] out_x;
  logic signed [WIDTH-1:0] out_y;
  logic signed [WIDTH-1:0] off_x;
  logic signed [WIDTH-1:0] off_y;
  logic                    sat;

  modport master (
    output out_valid, out_x, out_y, off_x, off_y, sat,
    input  out_ready
  );

  modport slave (
    input  out_valid, out_x, out_y, off_x, off_y, sat,
    output out_ready
  );
endinterface

// File: rtl/coord_scan_gen.sv
// Search-window coordinate generator: raster-walks a square offset window
// around a latched base and emits saturated coordinate pairs on a handshake.
module coord_scan_gen #(
  parameter int WIDTH = 8,
  parameter int RANGE = 4,
  parameter int STEP  = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    clear,
  input  logic signed [WIDTH-1:0] base_x,
  input  logic signed [WIDTH-1:0] base_y,
  coord_scan_gen_if.master        pts,
  output logic                    busy,
  output logic                    done
);

  if (WIDTH < 4 || RANGE < 1 || RANGE > (2 ** (WIDTH - 2)) - 1 ||
      STEP < 1 || (RANGE % STEP) != 0) begin : g_bad_param
    $error("coord_scan_gen: illegal WIDTH/RANGE/STEP combination");
  end

  localparam logic signed [WIDTH-1:0] NEG_R  = WIDTH'(-RANGE);
  localparam logic signed [WIDTH-1:0] POS_R  = WIDTH'(RANGE);
  localparam logic signed [WIDTH-1:0] STEP_W = WIDTH'(STEP);

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DONE
  } state_t;

  state_t                  state_q, state_d;
  logic signed [WIDTH-1:0] base_x_q, base_x_d;
  logic signed [WIDTH-1:0] base_y_q, base_y_d;
  logic signed [WIDTH-1:0] off_x_q, off_x_d;
  logic signed [WIDTH-1:0] off_y_q, off_y_d;
  logic                    valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      base_x_q <= '0;
      base_y_q <= '0;
      off_x_q  <= NEG_R;
      off_y_q  <= NEG_R;
    end else begin
      state_q  <= state_d;
      base_x_q <= base_x_d;
      base_y_q <= base_y_d;
      off_x_q  <= off_x_d;
      off_y_q  <= off_y_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    base_x_d = base_x_q;
    base_y_d = base_y_q;
    off_x_d  = off_x_q;
    off_y_d  = off_y_q;
    valid    = 1'b0;
    done     = 1'b0;
    if (clear) begin
      state_d = IDLE;
      off_x_d = NEG_R;
      off_y_d = NEG_R;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            state_d  = SCAN;
            base_x_d = base_x;
            base_y_d = base_y;
            off_x_d  = NEG_R;
            off_y_d  = NEG_R;
          end
        end
        SCAN: begin
          valid = 1'b1;
          if (pts.out_ready) begin
            if (off_x_q < POS_R) begin
              off_x_d = off_x_q + STEP_W;
            end else begin
              off_x_d = NEG_R;
              if (off_y_q < POS_R) off_y_d = off_y_q + STEP_W;
              else                 state_d = DONE;
            end
          end
        end
        DONE: begin
          done    = 1'b1;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Sum in WIDTH+1 bits; the top two bits differing marks overflow, and the
  // top bit then selects the clamp direction.
  logic signed [WIDTH:0] sum_x, sum_y;
  logic                  ovf_x, ovf_y;

  assign sum_x = {base_x_q[WIDTH-1], base_x_q} + {off_x_q[WIDTH-1], off_x_q};
  assign sum_y = {base_y_q[WIDTH-1], base_y_q} + {off_y_q[WIDTH-1], off_y_q};
  assign ovf_x = sum_x[WIDTH] ^ sum_x[WIDTH-1];
  assign ovf_y = sum_y[WIDTH] ^ sum_y[WIDTH-1];

  assign pts.out_x     = ovf_x ? {sum_x[WIDTH], {(WIDTH-1){~sum_x[WIDTH]}}}
                               : sum_x[WIDTH-1:0];
  assign pts.out_y     = ovf_y ? {sum_y[WIDTH], {(WIDTH-1){~sum_y[WIDTH]}}}
                               : sum_y[WIDTH-1:0];
  assign pts.sat       = ovf_x | ovf_y;
  assign pts.off_x     = off_x_q;
  assign pts.off_y     = off_y_q;
  assign pts.out_valid = valid;
  assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_coord_scan_gen.sv
// Directed bench for coord_scan_gen: STEP=1 and STEP=2 instances, WIDTH=8, RANGE=4.
module tb_coord_scan_gen;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic              start_a = 1'b0, clear_a = 1'b0, busy_a, done_a;
  logic signed [7:0] bx_a = '0, by_a = '0;
  logic              start_b = 1'b0, clear_b = 1'b0, busy_b, done_b;
  logic signed [7:0] bx_b = '0, by_b = '0;

  coord_scan_gen_if #(.WIDTH(8)) pa ();
  coord_scan_gen_if #(.WIDTH(8)) pb ();

  coord_scan_gen #(.WIDTH(8), .RANGE(4), .STEP(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .clear(clear_a),
    .base_x(bx_a), .base_y(by_a), .pts(pa.master), .busy(busy_a), .done(done_a)
  );

  coord_scan_gen #(.WIDTH(8), .RANGE(4), .STEP(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .clear(clear_b),
    .base_x(bx_b), .base_y(by_b), .pts(pb.master), .busy(busy_b), .done(done_b)
  );

  function automatic int clampv(input int v);
    if (v > 127)  return 127;
    if (v < -128) return -128;
    return v;
  endfunction

  task automatic kick_a(input int x, input int y);
    @(negedge clk);
    bx_a = 8'(x); by_a = 8'(y); start_a = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_a = 1'b0;
  endtask

  task automatic test_reset;
    pa.out_ready = 1'b1;
    pb.out_ready = 1'b1;
    #12;
    checks++;
    if (pa.out_valid !== 1'b0 || busy_a !== 1'b0 || done_a !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl got v=%b b=%b d=%b exp 0 0 0", pa.out_valid, busy_a, done_a);
    end
    checks++;
    if (pa.off_x !== -8'sd4 || pa.off_y !== -8'sd4) begin
      errors++;
      $display("FAIL reset_off got (%0d,%0d) exp (-4,-4)", pa.off_x, pa.off_y);
    end
    checks++;
    if (pa.out_x !== -8'sd4 || pa.out_y !== -8'sd4 || pa.sat !== 1'b0) begin
      errors++;
      $display("FAIL reset_out got (%0d,%0d,%b) exp (-4,-4,0)", pa.out_x, pa.out_y, pa.sat);
    end
    checks++;
    if (pb.out_valid !== 1'b0 || busy_b !== 1'b0 || pb.off_x !== -8'sd4) begin
      errors++;
      $display("FAIL reset_b got v=%b b=%b offx=%0d exp 0 0 -4", pb.out_valid, busy_b, pb.off_x);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_scan_basic;
    logic signed [7:0] ex, ey, eox, eoy;
    kick_a(10, -3);
    for (int k = 0; k < 81; k++) begin
      eox = 8'(-4 + k % 9); eoy = 8'(-4 + k / 9);
      ex  = 8'(clampv(10 + int'(eox))); ey = 8'(clampv(-3 + int'(eoy)));
      checks++;
      if (pa.out_valid !== 1'b1 || done_a !== 1'b0 || pa.sat !== 1'b0 ||
          pa.off_x !== eox || pa.off_y !== eoy || pa.out_x !== ex || pa.out_y !== ey) begin
        errors++;
        $display("FAIL scan_point k=%0d got v=%b d=%b s=%b off(%0d,%0d) out(%0d,%0d) exp 1 0 0 off(%0d,%0d) out(%0d,%0d)",
                 k, pa.out_valid, done_a, pa.sat, pa.off_x, pa.off_y, pa.out_x, pa.out_y, eox, eoy, ex, ey);
      end
      if (k == 0) begin
        checks++;
        if (pa.out_x !== 8'sd6 || pa.out_y !== -8'sd7) begin
          errors++;
          $display("FAIL scan_first got (%0d,%0d) exp (6,-7)", pa.out_x, pa.out_y);
        end
      end
      if (k == 9) begin
        checks++;
        if (pa.out_x !== 8'sd6 || pa.out_y !== -8'sd6) begin
          errors++;
          $display("FAIL scan_tenth got (%0d,%0d) exp (6,-6)", pa.out_x, pa.out_y);
        end
      end
      if (k == 80) begin
        checks++;
        if (pa.out_x !== 8'sd14 || pa.out_y !== 8'sd1) begin
          errors++;
          $display("FAIL scan_last got (%0d,%0d) exp (14,1)", pa.out_x, pa.out_y);
        end
      end
      @(posedge clk);
      @(negedge clk);
    end
    checks++;
    if (done_a !== 1'b1 || pa.out_valid !== 1'b0 || busy_a !== 1'b1) begin
      errors++;
      $display("FAIL scan_done got d=%b v=%b b=%b exp 1 0 1", done_a, pa.out_valid, busy_a);
    end
    @(negedge clk);
    checks++;
    if (done_a !== 1'b0 || busy_a !== 1'b0) begin
      errors++;
      $display("FAIL scan_idle got d=%b b=%b exp 0 0", done_a, busy_a);
    end
  endtask

  task automatic test_saturation;
    logic signed [7:0] ex, ey;
    logic es;
    int rx, ry;
    kick_a(125, -126);
    for (int k = 0; k < 81; k++) begin
      rx = 125 + (-4 + k % 9); ry = -126 + (-4 + k / 9);
      ex = 8'(clampv(rx)); ey = 8'(clampv(ry));
      es = (clampv(rx) != rx) || (clampv(ry) != ry);
      checks++;
      if (pa.out_x !== ex || pa.out_y !== ey || pa.sat !== es) begin
        errors++;
        $display("FAIL sat_point k=%0d got (%0d,%0d,%b) exp (%0d,%0d,%b)",
                 k, pa.out_x, pa.out_y, pa.sat, ex, ey, es);
      end
      if (k == 0 || k == 40 || k == 80) begin
        checks++;
        if ((k == 0  && (pa.out_x !== 8'sd121 || pa.out_y !== -8'sd128 || pa.sat !== 1'b1)) ||
            (k == 40 && (pa.out_x !== 8'sd125 || pa.out_y !== -8'sd126 || pa.sat !== 1'b0)) ||
            (k == 80 && (pa.out_x !== 8'sd127 || pa.out_y !== -8'sd122 || pa.sat !== 1'b1))) begin
          errors++;
          $display("FAIL sat_corner k=%0d got (%0d,%0d,%b)", k, pa.out_x, pa.out_y, pa.sat);
        end
      end
      @(posedge clk);
      @(negedge clk);
    end
    checks++;
    if (done_a !== 1'b1) begin
      errors++;
      $display("FAIL sat_done got %b exp 1", done_a);
    end
    @(negedge clk);
  endtask

  task automatic test_step2;
    logic signed [7:0] eox, eoy;
    @(negedge clk);
    bx_b = '0; by_b = '0; start_b = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_b = 1'b0;
    for (int k = 0; k < 25; k++) begin
      eox = 8'(-4 + 2 * (k % 5)); eoy = 8'(-4 + 2 * (k / 5));
      checks++;
      if (pb.out_valid !== 1'b1 || pb.off_x !== eox || pb.off_y !== eoy ||
          pb.out_x !== eox || pb.out_y !== eoy) begin
        errors++;
        $display("FAIL step2_point k=%0d got v=%b off(%0d,%0d) out(%0d,%0d) exp off/out (%0d,%0d)",
                 k, pb.out_valid, pb.off_x, pb.off_y, pb.out_x, pb.out_y, eox, eoy);
      end
      @(posedge clk);
      @(negedge clk);
    end
    checks++;
    if (done_b !== 1'b1 || pb.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL step2_done got d=%b v=%b exp 1 0", done_b, pb.out_valid);
    end
    @(negedge clk);
  endtask

  task automatic test_backpressure;
    logic signed [7:0] eox, eoy, ex, ey;
    int k = 0, cyc = 0, stall = 0;
    kick_a(10, -3);
    while (k < 81 && cyc < 300) begin
      if (k == 20 && stall < 5) begin
        pa.out_ready = 1'b0;
        stall++;
      end else begin
        pa.out_ready = 1'b1;
      end
      eox = 8'(-4 + k % 9); eoy = 8'(-4 + k / 9);
      ex = 8'(10 + int'(eox)); ey = 8'(-3 + int'(eoy));
      checks++;
      if (pa.out_valid !== 1'b1 || pa.off_x !== eox || pa.off_y !== eoy ||
          pa.out_x !== ex || pa.out_y !== ey || pa.sat !== 1'b0) begin
        errors++;
        $display("FAIL bp_point k=%0d got v=%b off(%0d,%0d) out(%0d,%0d) s=%b exp off(%0d,%0d) out(%0d,%0d) s=0",
                 k, pa.out_valid, pa.off_x, pa.off_y, pa.out_x, pa.out_y, pa.sat, eox, eoy, ex, ey);
      end
      @(posedge clk);
      if (pa.out_ready) k++;
      @(negedge clk);
      cyc++;
    end
    pa.out_ready = 1'b1;
    checks++;
    if (k != 81 || stall != 5 || done_a !== 1'b1) begin
      errors++;
      $display("FAIL bp_total got accepts=%0d stalls=%0d done=%b exp 81 5 1", k, stall, done_a);
    end
    @(negedge clk);
  endtask

  task automatic test_clear;
    logic signed [7:0] eox, eoy;
    int dones = 0;
    kick_a(10, -3);
    for (int k = 0; k < 30; k++) begin
      start_a = (k == 10);
      bx_a = (k == 10) ? 8'sd50 : 8'sd10;
      by_a = (k == 10) ? 8'sd50 : -8'sd3;
      eox = 8'(-4 + k % 9); eoy = 8'(-4 + k / 9);
      checks++;
      if (pa.off_x !== eox || pa.off_y !== eoy || pa.out_x !== 8'(10 + int'(eox))) begin
        errors++;
        $display("FAIL clr_run k=%0d got off(%0d,%0d) x=%0d exp off(%0d,%0d) x=%0d",
                 k, pa.off_x, pa.off_y, pa.out_x, eox, eoy, 10 + int'(eox));
      end
      @(posedge clk);
      @(negedge clk);
    end
    start_a = 1'b0;
    checks++;
    if (pa.off_x !== -8'sd1 || pa.off_y !== -8'sd1 || pa.out_valid !== 1'b1) begin
      errors++;
      $display("FAIL clr_pt30 got off(%0d,%0d) v=%b exp (-1,-1) 1", pa.off_x, pa.off_y, pa.out_valid);
    end
    clear_a = 1'b1;
    @(posedge clk);
    @(negedge clk);
    clear_a = 1'b0;
    checks++;
    if (pa.out_valid !== 1'b0 || busy_a !== 1'b0 || done_a !== 1'b0 ||
        pa.off_x !== -8'sd4 || pa.off_y !== -8'sd4) begin
      errors++;
      $display("FAIL clr_idle got v=%b b=%b d=%b off(%0d,%0d) exp 0 0 0 (-4,-4)",
               pa.out_valid, busy_a, done_a, pa.off_x, pa.off_y);
    end
    for (int i = 0; i < 4; i++) begin
      if (done_a) dones++;
      @(negedge clk);
    end
    checks++;
    if (dones != 0) begin
      errors++;
      $display("FAIL clr_nodone got %0d done cycles exp 0", dones);
    end
    start_a = 1'b1; clear_a = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_a = 1'b0; clear_a = 1'b0;
    checks++;
    if (busy_a !== 1'b0 || pa.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL clr_start_same got b=%b v=%b exp 0 0", busy_a, pa.out_valid);
    end
    kick_a(0, 0);
    checks++;
    if (pa.out_valid !== 1'b1 || pa.off_x !== -8'sd4 || pa.off_y !== -8'sd4 ||
        pa.out_x !== -8'sd4 || pa.out_y !== -8'sd4) begin
      errors++;
      $display("FAIL clr_restart got v=%b off(%0d,%0d) out(%0d,%0d) exp 1 (-4,-4) (-4,-4)",
               pa.out_valid, pa.off_x, pa.off_y, pa.out_x, pa.out_y);
    end
    clear_a = 1'b1;
    @(posedge clk);
    @(negedge clk);
    clear_a = 1'b0;
  endtask

  task automatic test_async_reset;
    int act = 0;
    kick_a(10, -3);
    repeat (5) begin
      @(posedge clk);
      @(negedge clk);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (pa.out_valid !== 1'b0 || busy_a !== 1'b0 || done_a !== 1'b0 ||
        pa.off_x !== -8'sd4 || pa.out_x !== -8'sd4) begin
      errors++;
      $display("FAIL areset got v=%b b=%b d=%b offx=%0d x=%0d exp 0 0 0 -4 -4",
               pa.out_valid, busy_a, done_a, pa.off_x, pa.out_x);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (pa.out_valid || busy_a || done_a) act++;
    end
    checks++;
    if (act != 0) begin
      errors++;
      $display("FAIL areset_quiet got %0d active cycles exp 0", act);
    end
  endtask

  initial begin
    test_reset();
    test_scan_basic();
    test_saturation();
    test_step2();
    test_backpressure();
    test_clear();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
